// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: FSM states,
// opcode constants, instruction classes and datapath select encodings.
package riscv_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        CLS_ILLEGAL = 3'd0,
        CLS_OP_IMM  = 3'd1,
        CLS_OP      = 3'd2,
        CLS_LOAD    = 3'd3,
        CLS_STORE   = 3'd4,
        CLS_AUIPC   = 3'd5,
        CLS_JAL     = 3'd6,
        CLS_BRANCH  = 3'd7
    } inst_class_t;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_U    = 3'd3,
        IMM_J    = 3'd4,
        IMM_B    = 3'd5
    } imm_sel_t;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2
    } pc_sel_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'd0,
        ALU_FUNCT = 2'd1,
        ALU_CMP   = 2'd2
    } alu_op_t;

endpackage

// File: rtl/main_decoder.sv
// Combinational opcode classifier: maps a 7-bit opcode to its instruction
// class and immediate format.
module main_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0]  opcode,
    output inst_class_t inst_class,
    output imm_sel_t    imm_sel
);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        inst_class = CLS_ILLEGAL;
        imm_sel    = IMM_NONE;
        case (opcode)
            OPC_OP_IMM: begin inst_class = CLS_OP_IMM; imm_sel = IMM_I; end
            OPC_OP:     begin inst_class = CLS_OP;     imm_sel = IMM_NONE; end
            OPC_LOAD:   begin inst_class = CLS_LOAD;   imm_sel = IMM_I; end
            OPC_STORE:  begin inst_class = CLS_STORE;  imm_sel = IMM_S; end
            OPC_AUIPC:  begin inst_class = CLS_AUIPC;  imm_sel = IMM_U; end
            OPC_JAL:    begin inst_class = CLS_JAL;    imm_sel = IMM_J; end
            OPC_BRANCH: begin inst_class = CLS_BRANCH; imm_sel = IMM_B; end
            default:    begin inst_class = CLS_ILLEGAL; imm_sel = IMM_NONE; end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP) with retire counter.
// Define MULTICYCLE_MEM_TIMEOUT_EN to trap when memory stalls TIMEOUT_CYCLES cycles.
module multicycle_control
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic        branch_taken,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_load,
    output logic        pc_write,
    output logic        reg_write,
    output logic [2:0]  imm_sel,
    output logic [1:0]  pc_sel,
    output logic [1:0]  wb_sel,
    output logic        alu_src,
    output logic [1:0]  alu_op,
    output logic        illegal,
    output logic        retire,
    output logic [31:0] retired_cnt
);

    state_t      state;
    logic [6:0]  op_q;
    logic [6:0]  dec_opcode;
    inst_class_t inst_class;
    imm_sel_t    dec_imm_sel;
    logic        wait_expired;

    // DECODE classifies the live opcode; later states use the registered copy.
    assign dec_opcode = (state == S_DECODE) ? opcode : op_q;

    main_decoder u_main_decoder (
        .opcode     (dec_opcode),
        .inst_class (inst_class),
        .imm_sel    (dec_imm_sel)
    );

`ifdef MULTICYCLE_MEM_TIMEOUT_EN
    localparam int unsigned WaitW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WaitW-1:0] wait_cnt;

    assign wait_expired = (wait_cnt == WaitW'(TIMEOUT_CYCLES - 1)) && !mem_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if ((state == S_FETCH || state == S_MEM) && !mem_ready && !wait_expired) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign wait_expired   = 1'b0;
`endif

    // NOTE: state is updated with non-blocking assignments and reset asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_FETCH;
            op_q        <= '0;
            retired_cnt <= '0;
        end else begin
            if (retire) begin
                retired_cnt <= retired_cnt + 32'd1;
            end
            case (state)
                S_FETCH: begin
                    if (mem_ready)         state <= S_DECODE;
                    else if (wait_expired) state <= S_TRAP;
                end
                S_DECODE: begin
                    op_q  <= opcode;
                    state <= (inst_class == CLS_ILLEGAL) ? S_TRAP : S_EXEC;
                end
                S_EXEC: begin
                    case (inst_class)
                        CLS_BRANCH, CLS_JAL:  state <= S_FETCH;
                        CLS_LOAD, CLS_STORE:  state <= S_MEM;
                        default:              state <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (mem_ready)         state <= (inst_class == CLS_STORE) ? S_FETCH : S_WB;
                    else if (wait_expired) state <= S_TRAP;
                end
                S_WB:    state <= S_FETCH;
                S_TRAP:  state <= S_TRAP;
                default: state <= S_FETCH;
            endcase
        end
    end

    // Outputs follow the state and same-cycle handshakes; reset blanks them at once.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        ir_load   = 1'b0;
        pc_write  = 1'b0;
        reg_write = 1'b0;
        imm_sel   = IMM_NONE;
        pc_sel    = PC_PLUS4;
        wb_sel    = WB_ALU;
        alu_src   = 1'b0;
        alu_op    = ALU_ADD;
        illegal   = 1'b0;
        retire    = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    ir_load = mem_ready;
                end
                S_EXEC: begin
                    imm_sel = dec_imm_sel;
                    case (inst_class)
                        CLS_BRANCH: begin
                            alu_op   = ALU_CMP;
                            pc_write = 1'b1;
                            pc_sel   = branch_taken ? PC_BRANCH : PC_PLUS4;
                            retire   = 1'b1;
                        end
                        CLS_JAL: begin
                            reg_write = 1'b1;
                            wb_sel    = WB_PC4;
                            pc_write  = 1'b1;
                            pc_sel    = PC_JUMP;
                            retire    = 1'b1;
                        end
                        CLS_OP_IMM: begin
                            alu_src = 1'b1;
                            alu_op  = ALU_FUNCT;
                        end
                        CLS_AUIPC: begin
                            alu_src = 1'b1;
                            alu_op  = ALU_ADD;
                        end
                        CLS_OP: begin
                            alu_src = 1'b0;
                            alu_op  = ALU_FUNCT;
                        end
                        CLS_LOAD, CLS_STORE: begin
                            alu_src = 1'b1;
                            alu_op  = ALU_ADD;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    imm_sel = dec_imm_sel;
                    mem_req = 1'b1;
                    if (inst_class == CLS_STORE) begin
                        mem_we   = 1'b1;
                        pc_write = mem_ready;
                        retire   = mem_ready;
                    end
                end
                S_WB: begin
                    reg_write = 1'b1;
                    wb_sel    = (inst_class == CLS_LOAD) ? WB_MEM : WB_ALU;
                    pc_write  = 1'b1;
                    retire    = 1'b1;
                end
                S_TRAP:  illegal = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control; timeout checks follow MULTICYCLE_MEM_TIMEOUT_EN.
module tb_multicycle_control;

    logic        clock = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic        branch_taken;
    logic        mem_ready;
    logic        mem_req, mem_we, ir_load, pc_write, reg_write;
    logic [2:0]  imm_sel;
    logic [1:0]  pc_sel, wb_sel, alu_op;
    logic        alu_src, illegal, retire;
    logic [31:0] retired_cnt;

    int total = 0;
    int bad   = 0;

    multicycle_control #(.TIMEOUT_CYCLES(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .ir_load      (ir_load),
        .pc_write     (pc_write),
        .reg_write    (reg_write),
        .imm_sel      (imm_sel),
        .pc_sel       (pc_sel),
        .wb_sel       (wb_sel),
        .alu_src      (alu_src),
        .alu_op       (alu_op),
        .illegal      (illegal),
        .retire       (retire),
        .retired_cnt  (retired_cnt)
    );

    always #5 clock = ~clock;

    // Control vector: {mem_req, mem_we, ir_load, pc_write, reg_write, imm_sel,
    //                  pc_sel, wb_sel, alu_src, alu_op, illegal, retire}
    logic [16:0] obs;
    assign obs = {mem_req, mem_we, ir_load, pc_write, reg_write, imm_sel,
                  pc_sel, wb_sel, alu_src, alu_op, illegal, retire};

    localparam logic [16:0] MREQ = 17'h1 << 16;
    localparam logic [16:0] MWE  = 17'h1 << 15;
    localparam logic [16:0] IRL  = 17'h1 << 14;
    localparam logic [16:0] PCW  = 17'h1 << 13;
    localparam logic [16:0] RW   = 17'h1 << 12;
    localparam logic [16:0] ASRC = 17'h1 << 4;
    localparam logic [16:0] ILL  = 17'h1 << 1;
    localparam logic [16:0] RET  = 17'h1;

    function automatic logic [16:0] imm(input int v); return 17'(v) << 9; endfunction
    function automatic logic [16:0] pcs(input int v); return 17'(v) << 7; endfunction
    function automatic logic [16:0] wbs(input int v); return 17'(v) << 5; endfunction
    function automatic logic [16:0] aop(input int v); return 17'(v) << 2; endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge with inputs set; checks mid-cycle, advances one cycle.
    task automatic chk_cycle(input string tag, input logic [16:0] exp);
        @(negedge clock);
        check(tag, 32'(obs), 32'(exp));
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset        = 1'b1;
        opcode       = 7'h00;
        branch_taken = 1'b0;
        mem_ready    = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("rst_ctl", 32'(obs), 32'h0);
        check("rst_cnt", retired_cnt, 32'd0);

        // addi x0,x1,-3 with single-cycle memory
        reset  = 1'b0;
        opcode = 7'h13;
        chk_cycle("addi_fetch",  MREQ | IRL);
        chk_cycle("addi_decode", 17'h0);
        chk_cycle("addi_exec",   imm(1) | ASRC | aop(1));
        chk_cycle("addi_wb",     RW | PCW | RET | wbs(0));
        check("addi_cnt", retired_cnt, 32'd1);

        // sw with three wait cycles in MEM
        opcode = 7'h23;
        chk_cycle("sw_fetch",  MREQ | IRL);
        chk_cycle("sw_decode", 17'h0);
        mem_ready = 1'b0;
        chk_cycle("sw_exec",   imm(2) | ASRC | aop(0));
        for (int i = 0; i < 3; i++) chk_cycle("sw_mem_wait", MREQ | MWE | imm(2));
        mem_ready = 1'b1;
        chk_cycle("sw_mem_done", MREQ | MWE | imm(2) | PCW | RET);
        check("sw_cnt", retired_cnt, 32'd2);

        // beq taken, then not taken
        opcode       = 7'h63;
        branch_taken = 1'b1;
        chk_cycle("beq_t_fetch",  MREQ | IRL);
        chk_cycle("beq_t_decode", 17'h0);
        chk_cycle("beq_t_exec",   imm(5) | aop(2) | PCW | pcs(1) | RET);
        check("beq_t_cnt", retired_cnt, 32'd3);
        branch_taken = 1'b0;
        chk_cycle("beq_n_fetch",  MREQ | IRL);
        chk_cycle("beq_n_decode", 17'h0);
        chk_cycle("beq_n_exec",   imm(5) | aop(2) | PCW | pcs(0) | RET);
        check("beq_n_cnt", retired_cnt, 32'd4);

        // jal
        opcode = 7'h6F;
        chk_cycle("jal_fetch",  MREQ | IRL);
        chk_cycle("jal_decode", 17'h0);
        chk_cycle("jal_exec",   imm(4) | RW | wbs(2) | PCW | pcs(2) | RET);
        check("jal_cnt", retired_cnt, 32'd5);

        // lw, full five-cycle path
        opcode = 7'h03;
        chk_cycle("lw_fetch",  MREQ | IRL);
        chk_cycle("lw_decode", 17'h0);
        chk_cycle("lw_exec",   imm(1) | ASRC | aop(0));
        chk_cycle("lw_mem",    MREQ | imm(1));
        chk_cycle("lw_wb",     RW | wbs(1) | PCW | RET);
        check("lw_cnt", retired_cnt, 32'd6);

        // lw interrupted by reset while MEM waits
        chk_cycle("lw2_fetch",  MREQ | IRL);
        chk_cycle("lw2_decode", 17'h0);
        chk_cycle("lw2_exec",   imm(1) | ASRC | aop(0));
        mem_ready = 1'b0;
        @(negedge clock);
        check("lw2_mem", 32'(obs), 32'(MREQ | imm(1)));
        #1 reset = 1'b1;
        #1 check("rst_mid_mem", 32'(obs), 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst_mid_cnt", retired_cnt, 32'd0);
        chk_cycle("post_rst_fetch", MREQ);

        // illegal opcode traps from DECODE and stays until reset
        mem_ready = 1'b1;
        opcode    = 7'h7F;
        chk_cycle("ill_fetch",  MREQ | IRL);
        chk_cycle("ill_decode", 17'h0);
        for (int i = 0; i < 20; i++) chk_cycle("ill_trap", ILL);
        reset = 1'b1;
        #1 check("trap_rst", 32'(obs), 32'h0);
        @(posedge clock);
        #1;
        reset     = 1'b0;
        mem_ready = 1'b0;
        check("trap_rst_cnt", retired_cnt, 32'd0);

`ifdef MULTICYCLE_MEM_TIMEOUT_EN
        for (int i = 0; i < 16; i++) chk_cycle("to_wait", MREQ);
        chk_cycle("to_trap", ILL);
        chk_cycle("to_trap_hold", ILL);
`else
        for (int i = 0; i < 40; i++) chk_cycle("nto_wait", MREQ);
        mem_ready = 1'b1;
        chk_cycle("nto_fetch_done", MREQ | IRL);
        chk_cycle("nto_decode", 17'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
